// File: rtl/serial_mod_tx.sv
// MSB-first parallel-to-serial transmitter that tracks the word's remainder modulo DIVISOR.
// Define SERIAL_MOD_TX_SUFFIX_EN to append an RW-bit check suffix that makes the whole stream a multiple of DIVISOR.
module serial_mod_tx #(
  parameter int WIDTH   = 8,
  parameter int DIVISOR = 5,
  localparam int RW     = $clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_last,
  output logic [RW-1:0]    rem,
  output logic             rem_valid
);

  localparam int CW = 7;
  localparam logic [RW:0] DIV_W = (RW+1)'(DIVISOR);

`ifdef SERIAL_MOD_TX_SUFFIX_EN
  typedef enum logic [1:0] {IDLE, SHIFT, SUFFIX, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic [RW-1:0]    rem_q, rem_d;

  // One doubling step of the remainder; 2*a+b < 2*DIVISOR, so a single subtraction suffices.
  function automatic logic [RW-1:0] mod_step(input logic [RW-1:0] a, input logic b);
    logic [RW:0] t;
    t = {a, b};
    if (t >= DIV_W) t = t - DIV_W;
    return t[RW-1:0];
  endfunction

`ifdef SERIAL_MOD_TX_SUFFIX_EN
  localparam logic [RW-1:0] DIV_LO = RW'(DIVISOR);

  logic [RW-1:0] sfx_q, sfx_d;
  logic [RW-1:0] r_q, r_d;

  // Suffix s satisfies (r * 2^RW + s) mod DIVISOR == 0.
  function automatic logic [RW-1:0] suffix_of(input logic [RW-1:0] r);
    logic [RW-1:0] t;
    t = r;
    for (int i = 0; i < RW; i++) t = mod_step(t, 1'b0);
    if (t == '0) return '0;
    return DIV_LO - t;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
`ifdef SERIAL_MOD_TX_SUFFIX_EN
    sfx_d   = sfx_q;
    r_d     = r_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = in_data;
          cnt_d   = CW'(WIDTH);
          acc_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = shift_q << 1;
        cnt_d   = cnt_q - CW'(1);
        acc_d   = mod_step(acc_q, shift_q[WIDTH-1]);
        if (cnt_q == CW'(1)) begin
`ifdef SERIAL_MOD_TX_SUFFIX_EN
          r_d     = acc_d;
          sfx_d   = suffix_of(acc_d);
          cnt_d   = CW'(RW);
          state_d = SUFFIX;
`else
          rem_d   = acc_d;
          state_d = DONE;
`endif
        end
      end
`ifdef SERIAL_MOD_TX_SUFFIX_EN
      SUFFIX: begin
        sfx_d = sfx_q << 1;
        cnt_d = cnt_q - CW'(1);
        acc_d = mod_step(acc_q, sfx_q[RW-1]);
        if (cnt_q == CW'(1)) begin
          rem_d   = r_q;
          state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
`ifdef SERIAL_MOD_TX_SUFFIX_EN
      sfx_q   <= '0;
      r_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
`ifdef SERIAL_MOD_TX_SUFFIX_EN
      sfx_q   <= sfx_d;
      r_q     <= r_d;
`endif
    end
  end

  // All outputs decode registered state only.
  always_comb begin
    in_ready   = (state_q == IDLE);
    rem_valid  = (state_q == DONE);
    rem        = rem_q;
    dout       = 1'b0;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    if (state_q == SHIFT) begin
      dout       = shift_q[WIDTH-1];
      dout_valid = 1'b1;
`ifndef SERIAL_MOD_TX_SUFFIX_EN
      dout_last  = (cnt_q == CW'(1));
`endif
    end
`ifdef SERIAL_MOD_TX_SUFFIX_EN
    if (state_q == SUFFIX) begin
      dout       = sfx_q[RW-1];
      dout_valid = 1'b1;
      dout_last  = (cnt_q == CW'(1));
    end
`endif
  end

`ifdef SERIAL_MOD_TX_SUFFIX_EN
  suffix_zero_a: assert property (@(posedge clk) disable iff (!resetn)
    (state_q == SUFFIX && cnt_q == CW'(1)) |-> (acc_d == '0));
`endif

endmodule

// File: tb/tb_serial_mod_tx.sv
// Randomized self-checking bench for serial_mod_tx; expected streams and remainders come from plain arithmetic.
// Follows SERIAL_MOD_TX_SUFFIX_EN when defined.
module tb_serial_mod_tx;

  localparam int W  = 8;
  localparam int D  = 5;
  localparam int RW = $clog2(D);
`ifdef SERIAL_MOD_TX_SUFFIX_EN
  localparam int NB = W + RW;
`else
  localparam int NB = W;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          dout;
  logic          dout_valid;
  logic          dout_last;
  logic [RW-1:0] rem;
  logic          rem_valid;

  int total_checks  = 0;
  int passed_checks = 0;

  serial_mod_tx #(.WIDTH(W), .DIVISOR(D)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_last (dout_last),
    .rem       (rem),
    .rem_valid (rem_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total_checks++;
    if (observed === expected) passed_checks++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
  endtask

  // Transmitted stream: data word, followed by the check suffix when enabled.
  function automatic logic [NB-1:0] model_stream(input logic [W-1:0] word);
`ifdef SERIAL_MOD_TX_SUFFIX_EN
    int r, s;
    r = int'(word) % D;
    s = (D - ((r * (1 << RW)) % D)) % D;
    return {word, RW'(s)};
`else
    return word;
`endif
  endfunction

  // Entered and left at a falling edge with the DUT idle; optionally leaves in_valid high with the next word.
  task automatic applyStimulus(input logic [W-1:0] word, input bit hold, input logic [W-1:0] next_word);
    logic [NB-1:0] stream;
    int            exp_rem;
    stream  = model_stream(word);
    exp_rem = int'(word) % D;
    checkOutput("ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = word;
    @(negedge clk);
    if (hold) in_data = next_word;
    else in_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      checkOutput("dout_valid", 64'(dout_valid), 64'd1);
      checkOutput("dout", 64'(dout), 64'(stream[NB-1-i]));
      checkOutput("dout_last", 64'(dout_last), 64'(i == NB-1));
      checkOutput("ready_busy", 64'(in_ready), 64'd0);
      checkOutput("rem_valid_busy", 64'(rem_valid), 64'd0);
      @(negedge clk);
    end
    checkOutput("done_dout_valid", 64'(dout_valid), 64'd0);
    checkOutput("done_dout_last", 64'(dout_last), 64'd0);
    checkOutput("done_ready", 64'(in_ready), 64'd0);
    checkOutput("rem_valid", 64'(rem_valid), 64'd1);
    checkOutput("rem", 64'(rem), 64'(exp_rem));
    @(negedge clk);
    checkOutput("ready_again", 64'(in_ready), 64'd1);
    checkOutput("rem_valid_single", 64'(rem_valid), 64'd0);
    checkOutput("rem_hold", 64'(rem), 64'(exp_rem));
  endtask

  initial begin
    logic [W-1:0] w, nxt;
    bit           hold;

    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_dout", 64'(dout), 64'd0);
    checkOutput("rst_dout_valid", 64'(dout_valid), 64'd0);
    checkOutput("rst_dout_last", 64'(dout_last), 64'd0);
    checkOutput("rst_rem", 64'(rem), 64'd0);
    checkOutput("rst_rem_valid", 64'(rem_valid), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    applyStimulus(W'(25), 1'b0, '0);
    applyStimulus(W'(7), 1'b0, '0);
    applyStimulus(W'(8'hFF), 1'b0, '0);
    applyStimulus(W'(0), 1'b0, '0);
    applyStimulus(W'(128), 1'b0, '0);

    // in_valid held high across two words: second word is taken as soon as the block is idle again.
    applyStimulus(W'(25), 1'b1, W'(7));
    applyStimulus(W'(7), 1'b0, '0);

    // Reset asserted during cycle 4 of a frame aborts it without a remainder pulse.
    in_valid = 1'b1;
    in_data  = W'(25);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    checkOutput("abort_dout_valid", 64'(dout_valid), 64'd0);
    checkOutput("abort_ready", 64'(in_ready), 64'd1);
    checkOutput("abort_rem", 64'(rem), 64'd0);
    for (int i = 0; i < NB + 3; i++) begin
      checkOutput("abort_no_rem_valid", 64'(rem_valid), 64'd0);
      checkOutput("abort_idle_valid", 64'(dout_valid), 64'd0);
      @(negedge clk);
    end
    applyStimulus(W'(7), 1'b0, '0);

    w = W'($urandom);
    for (int k = 0; k < 30; k++) begin
      nxt  = W'($urandom);
      hold = 1'($urandom_range(0, 1));
      applyStimulus(w, hold, nxt);
      if (!hold) begin
        repeat ($urandom_range(0, 2)) begin
          checkOutput("gap_dout_valid", 64'(dout_valid), 64'd0);
          checkOutput("gap_ready", 64'(in_ready), 64'd1);
          @(negedge clk);
        end
      end
      w = nxt;
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
